// File: rtl/m10k_pkg.sv
// Definitions shared by the M10K write path: geometry defaults and the
// write-arbiter state encoding.
package m10k_pkg;

   localparam int M10K_DATA_LEN     = 32;
   localparam int M10K_N            = 8;
   localparam int M10K_ADDRESS_SIZE = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/m10k_wr_arb_rr_pick.sv
// Round-robin priority picker: finds the first set request bit at or above
// ptr, wrapping past the top requester back to requester 0.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [IDX_W:0]       off;
   logic [IDX_W:0]       sum;

   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: NUM_REQ];

   always_comb begin
      off = '0;
      any = 1'b0;
      // walk downward so the smallest offset from ptr wins
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            off = (IDX_W + 1)'(i);
            any = 1'b1;
         end
      end
      sum = {1'b0, ptr} + off;
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
         sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/m10k_wr_arb.sv
// M10K write-port arbiter: grants one requester at a time a fixed-length
// burst of row writes, round-robin between requesters.
//
// state | meaning
// IDLE  | port free, arbitrating among i_req
// BURST | port owned by gnt_idx; one row written per valid beat
// DONE  | one-cycle o_done pulse, advance round-robin pointer
module m10k_wr_arb
   import m10k_pkg::*;
#(
   parameter int DATA_LEN     = M10K_DATA_LEN,
   parameter int N            = M10K_N,
   parameter int ADDRESS_SIZE = M10K_ADDRESS_SIZE,
   parameter int NUM_REQ      = 4,
   parameter int BURST_LEN    = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rstn,
   input  logic [NUM_REQ-1:0]               i_req,
   input  logic [NUM_REQ*ADDRESS_SIZE-1:0]  i_base_addr,
   input  logic [NUM_REQ-1:0]               i_wr_valid,
   input  logic [NUM_REQ*DATA_LEN*N-1:0]    i_wr_data,
   output logic [NUM_REQ-1:0]               o_grant,
   output logic [NUM_REQ-1:0]               o_beat_ack,
   output logic [NUM_REQ-1:0]               o_done,
   output logic [ADDRESS_SIZE-1:0]          o_write_addr,
   output logic [DATA_LEN*N-1:0]            o_write_data,
   output logic                             o_write_start,
   output logic [1:0]                       o_state
);

   localparam int ROW_W  = DATA_LEN * N;
   localparam int IDX_W  = (NUM_REQ > 2) ? 2 : 1;
   localparam int BEAT_W = 3;

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        rr_ptr, gnt_idx, pick_idx, ptr_nxt;
   logic                    pick_any;
   logic [BEAT_W-1:0]       beat;
   logic [ADDRESS_SIZE-1:0] base;
   logic                    beat_fire, last_beat;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req (i_req),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign beat_fire = (state == BURST) && i_wr_valid[gnt_idx];
   assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
   assign ptr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         gnt_idx <= '0;
         beat    <= '0;
         base    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_idx <= pick_idx;
                  base    <= i_base_addr[pick_idx*ADDRESS_SIZE +: ADDRESS_SIZE];
                  beat    <= '0;
               end
            end
            BURST: begin
               if (beat_fire && !last_beat) begin
                  beat <= beat + BEAT_W'(1);
               end
            end
            DONE:    rr_ptr <= ptr_nxt;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = BURST;
         BURST:   if (beat_fire && last_beat) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_grant       = '0;
      o_beat_ack    = '0;
      o_done        = '0;
      o_write_start = 1'b0;
      o_write_addr  = '0;
      o_write_data  = '0;
      if (state == BURST) o_grant[gnt_idx] = 1'b1;
      if (state == DONE)  o_done[gnt_idx]  = 1'b1;
      // address wraps silently at the top of the M10K
      if (beat_fire) begin
         o_write_start       = 1'b1;
         o_beat_ack[gnt_idx] = 1'b1;
         o_write_addr        = base + ADDRESS_SIZE'(beat);
         o_write_data        = i_wr_data[gnt_idx*ROW_W +: ROW_W];
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_m10k_wr_arb.sv
// Directed bench for m10k_wr_arb: vector table for single/wrap bursts plus
// hand sequences for contention, stalls, mid-burst reset and isolation.
module tb_m10k_wr_arb;

   localparam int DL = 32;
   localparam int NE = 8;
   localparam int AW = 4;
   localparam int NR = 4;
   localparam int BL = 4;
   localparam int RW = DL * NE;

   logic             clk = 1'b0;
   logic             rstn;
   logic [NR-1:0]    req, valid;
   logic [NR*AW-1:0] base_addr;
   logic [NR*RW-1:0] wr_data;
   logic [NR-1:0]    grant, ack, done;
   logic [AW-1:0]    waddr;
   logic [RW-1:0]    wdata;
   logic             wstart;
   logic [1:0]       st;

   logic [RW-1:0]    row_d [NR];
   logic [AW-1:0]    base_d [NR];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] valid;
      logic [3:0] grant;
      logic [3:0] ack;
      logic       ws;
      logic [3:0] addr;
      logic [3:0] done;
      logic [1:0] st;
      int         src;
   } vec_t;

   vec_t vt [14];

   always #5 clk = ~clk;

   m10k_wr_arb #(
      .DATA_LEN     (DL),
      .N            (NE),
      .ADDRESS_SIZE (AW),
      .NUM_REQ      (NR),
      .BURST_LEN    (BL)
   ) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_req         (req),
      .i_base_addr   (base_addr),
      .i_wr_valid    (valid),
      .i_wr_data     (wr_data),
      .o_grant       (grant),
      .o_beat_ack    (ack),
      .o_done        (done),
      .o_write_addr  (waddr),
      .o_write_data  (wdata),
      .o_write_start (wstart),
      .o_state       (st)
   );

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         wr_data[r*RW +: RW]   = row_d[r];
         base_addr[r*AW +: AW] = base_d[r];
      end
   endtask

   task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic exp_cyc(input string tag, input logic [3:0] g, input logic [3:0] a,
                          input logic ws, input logic [3:0] ad, input logic [3:0] dn,
                          input logic [1:0] s, input int src);
      logic [RW-1:0] ed;
      ed = (ws && src >= 0) ? row_d[src] : '0;
      chk({tag, ".grant"}, RW'(grant), RW'(g));
      chk({tag, ".ack"},   RW'(ack),   RW'(a));
      chk({tag, ".wstart"}, RW'(wstart), RW'(ws));
      chk({tag, ".addr"},  RW'(waddr), RW'(ad));
      chk({tag, ".data"},  wdata, ed);
      chk({tag, ".done"},  RW'(done),  RW'(dn));
      chk({tag, ".state"}, RW'(st),    RW'(s));
   endtask

   task automatic do_reset();
      @(negedge clk);
      req   = 4'b1111;
      valid = 4'b1111;
      rstn  = 1'b0;
      #1;
      exp_cyc("reset", 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
      req = 4'b0000;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      logic [12:0] vpat, wpat;
      logic [3:0]  ad;
      int          nw, act_w;

      rstn  = 1'b0;
      req   = '0;
      valid = '0;
      for (int r = 0; r < NR; r++) begin
         for (int e = 0; e < NE; e++) row_d[r][e*DL +: DL] = $urandom;
         base_d[r] = 4'(r * 3);
      end
      base_d[0] = 4'd12;
      base_d[1] = 4'd14;
      drive();

      // table: single requester at base 12, then requester 1 wrapping from 14
      vt[0]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0,  4'b0000, 2'd0, -1};
      vt[1]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 1'b1, 4'd12, 4'b0000, 2'd1,  0};
      vt[2]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 1'b1, 4'd13, 4'b0000, 2'd1,  0};
      vt[3]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 1'b1, 4'd14, 4'b0000, 2'd1,  0};
      vt[4]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 1'b1, 4'd15, 4'b0000, 2'd1,  0};
      vt[5]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0,  4'b0001, 2'd2, -1};
      vt[6]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0,  4'b0000, 2'd0, -1};
      vt[7]  = '{4'b0010, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0,  4'b0000, 2'd0, -1};
      vt[8]  = '{4'b0010, 4'b1111, 4'b0010, 4'b0010, 1'b1, 4'd14, 4'b0000, 2'd1,  1};
      vt[9]  = '{4'b0010, 4'b1111, 4'b0010, 4'b0010, 1'b1, 4'd15, 4'b0000, 2'd1,  1};
      vt[10] = '{4'b0010, 4'b1111, 4'b0010, 4'b0010, 1'b1, 4'd0,  4'b0000, 2'd1,  1};
      vt[11] = '{4'b0010, 4'b1111, 4'b0010, 4'b0010, 1'b1, 4'd1,  4'b0000, 2'd1,  1};
      vt[12] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0,  4'b0010, 2'd2, -1};
      vt[13] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd0,  4'b0000, 2'd0, -1};

      // outputs must be zero while reset is held, even with live inputs
      @(negedge clk);
      req   = 4'b1111;
      valid = 4'b1111;
      #1;
      exp_cyc("in_reset", 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
      req = 4'b0000;
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         req   = vt[i].req;
         valid = vt[i].valid;
         drive();
         #1;
         exp_cyc($sformatf("vec%0d", i), vt[i].grant, vt[i].ack, vt[i].ws,
                 vt[i].addr, vt[i].done, vt[i].st, vt[i].src);
      end

      // contention: all four request continuously; expect 0,1,2,3,0
      base_d[0] = 4'd3;  base_d[1] = 4'd7;  base_d[2] = 4'd11;  base_d[3] = 4'd2;
      drive();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         int r;
         r = k % NR;
         @(negedge clk);
         req   = 4'b1111;
         valid = 4'b1111;
         #1;
         exp_cyc($sformatf("cont%0d.idle", k), 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
         for (int b = 0; b < BL; b++) begin
            @(negedge clk);
            #1;
            ad = base_d[r] + 4'(b);
            exp_cyc($sformatf("cont%0d.b%0d", k, b), 4'(1 << r), 4'(1 << r), 1'b1,
                    ad, 4'b0, 2'd1, r);
         end
         @(negedge clk);
         #1;
         exp_cyc($sformatf("cont%0d.done", k), 4'b0, 4'b0, 1'b0, 4'd0, 4'(1 << r), 2'd2, -1);
      end

      // stalls on beats 1 and 2; requester drops i_req once granted
      base_d[0] = 4'd3;
      drive();
      do_reset();
      vpat  = 13'b0011000100011;
      wpat  = 13'b0011000100010;
      nw    = 0;
      act_w = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         req   = (c == 0) ? 4'b0001 : 4'b0000;
         valid = {3'b111, vpat[c]};
         #1;
         act_w += int'(wstart);
         chk($sformatf("stall.c%0d.wstart", c), RW'(wstart), RW'(wpat[c]));
         if (wpat[c]) begin
            ad = base_d[0] + 4'(nw);
            chk($sformatf("stall.c%0d.addr", c), RW'(waddr), RW'(ad));
            nw++;
         end
         chk($sformatf("stall.c%0d.done", c), RW'(done), RW'((c == 11) ? 4'b0001 : 4'b0000));
      end
      chk("stall.writes", RW'(act_w), RW'(4));

      // reset after the second write abandons the burst
      base_d[0] = 4'd5;
      base_d[1] = 4'd9;
      drive();
      do_reset();
      @(negedge clk);
      req   = 4'b0001;
      valid = 4'b1111;
      #1;
      exp_cyc("mrst.idle", 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         #1;
         exp_cyc($sformatf("mrst.b%0d", b), 4'b0001, 4'b0001, 1'b1, 4'(5 + b), 4'b0, 2'd1, 0);
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      exp_cyc("mrst.assert", 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         exp_cyc($sformatf("mrst.hold%0d", c), 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
      end
      @(negedge clk);
      req  = 4'b0010;
      rstn = 1'b1;
      #1;
      exp_cyc("mrst.release", 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
      @(negedge clk);
      #1;
      exp_cyc("mrst.req1", 4'b0010, 4'b0010, 1'b1, 4'd9, 4'b0, 2'd1, 1);

      // isolation: requester 2 toggles valid and data while 0 owns the port
      base_d[0] = 4'd7;
      drive();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         req   = (c < 5) ? 4'b0101 : 4'b0000;
         valid = {1'b0, c[0], 1'b0, 1'b1};
         for (int e = 0; e < NE; e++) row_d[2][e*DL +: DL] = $urandom;
         drive();
         #1;
         if (c == 0 || c == 6)
            exp_cyc($sformatf("iso.c%0d", c), 4'b0, 4'b0, 1'b0, 4'd0, 4'b0, 2'd0, -1);
         else if (c == 5)
            exp_cyc("iso.done", 4'b0, 4'b0, 1'b0, 4'd0, 4'b0001, 2'd2, -1);
         else
            exp_cyc($sformatf("iso.c%0d", c), 4'b0001, 4'b0001, 1'b1, 4'(7 + c - 1),
                    4'b0, 2'd1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/m10k_wr_arb.md
M10K_WR_ARB -- requirements
Module: m10k_wr_arb

Interface
REQ-001 The parameter DATA_LEN SHALL default to 32 and sets the element width in bits.
REQ-002 The parameter N SHALL default to 8 and sets the elements per M10K row, so one row is DATA_LEN*N bits.
REQ-003 The parameter ADDRESS_SIZE SHALL default to 4 and sets the M10K address width.
REQ-004 The parameter NUM_REQ SHALL default to 4 and sets the requester count; the legal range is 2..4.
REQ-005 The parameter BURST_LEN SHALL default to 4 and sets the rows per granted burst; the legal range is 1..8.
REQ-006 i_clk  in  1  is the single clock; the block has one clock, and all state updates on its rising edge.
REQ-007 i_rstn  in  1  is the reset; it is asynchronous and active-low.
REQ-008 i_req  in  NUM_REQ  is the per-requester burst request, level, held until that requester's o_done bit pulses.
REQ-009 i_base_addr  in  NUM_REQ*ADDRESS_SIZE  is the per-requester burst start address; slice r belongs to requester r.
REQ-010 i_wr_valid  in  NUM_REQ  is the per-requester flag that the current row data is valid.
REQ-011 i_wr_data  in  NUM_REQ*DATA_LEN*N  is the per-requester row data; slice r belongs to requester r.
REQ-012 o_grant  out  NUM_REQ  is the one-hot owner of the M10K write port; it is all-zero when no requester owns the port.
REQ-013 o_beat_ack  out  NUM_REQ  indicates that the granted requester's row was accepted this cycle.
REQ-014 o_done  out  NUM_REQ  is a one-cycle pulse marking burst completion for the requester that owned the port.
REQ-015 o_write_addr  out  ADDRESS_SIZE  is the M10K write address.
REQ-016 o_write_data  out  DATA_LEN*N  is the M10K write data.
REQ-017 o_write_start  out  1  is the M10K write enable.
REQ-018 o_state  out  2  exposes the current FSM state for debug.

Function
REQ-019 The FSM SHALL have exactly these states and encodings: IDLE=0, BURST=1, DONE=2; encoding 3 SHALL be illegal and SHALL go to IDLE on the next edge.
REQ-020 In IDLE with i_req all zero, the FSM SHALL stay in IDLE.
REQ-021 In IDLE with any i_req bit set, the arbiter SHALL pick the first set bit, searching round-robin from the pointer rr_ptr upward.
REQ-022 On that IDLE-to-BURST transition, the block SHALL register the chosen requester as gnt_idx, register that requester's i_base_addr as base, and clear the beat counter to 0.
REQ-023 The arbitration decision SHALL take one cycle: a request first seen in IDLE at edge t SHALL receive o_grant from cycle t+1.
REQ-024 In BURST, o_grant SHALL equal onehot(gnt_idx); in every other state o_grant SHALL be zero.
REQ-025 In BURST with i_wr_valid[gnt_idx]=1, o_write_start, o_beat_ack[gnt_idx], o_write_data and o_write_addr SHALL all be combinational in the same cycle.
REQ-026 In that case o_write_start and o_beat_ack[gnt_idx] SHALL be 1, and o_write_data SHALL be slice gnt_idx of i_wr_data.
REQ-027 In that case o_write_addr SHALL be (base+beat) mod 2^ADDRESS_SIZE, so the address wraps silently past the top of the address space.
REQ-028 In that case the beat counter SHALL increment; when beat equals BURST_LEN-1, the FSM SHALL go to DONE instead.
REQ-029 In BURST with i_wr_valid[gnt_idx]=0, the block SHALL insert a stall: o_write_start=0, no acknowledge, beat held, state held.
REQ-030 There SHALL be no stall timeout.
REQ-031 In BURST, the i_wr_valid, i_req and i_base_addr inputs of non-granted requesters SHALL be ignored.
REQ-032 Deassertion of i_req[gnt_idx] during BURST SHALL be ignored, and the burst SHALL run to completion.
REQ-033 In DONE, o_done[gnt_idx] SHALL be 1 for exactly one cycle, rr_ptr SHALL become (gnt_idx+1) mod NUM_REQ, and the next state SHALL be IDLE.
REQ-034 A requester whose i_req is still high after its o_done pulse SHALL be treated as a new request.
REQ-035 The minimum burst duration SHALL be BURST_LEN+2 cycles from grant decision to the return to IDLE.
REQ-036 Outside BURST-with-valid, o_write_start, o_write_addr, o_write_data and o_beat_ack SHALL all be zero.
REQ-037 Exactly one M10K write SHALL occur per beat, and the port SHALL never carry data from two requesters in one burst.

Reset
REQ-038 Assertion of i_rstn low SHALL immediately force state=IDLE, rr_ptr=0, gnt_idx=0, beat=0 and base=0.
REQ-039 During reset, every output SHALL be zero, and o_state SHALL read 0.
REQ-040 Reset mid-burst SHALL abandon the burst without an o_done pulse; rows already written are not rolled back.
REQ-041 After deassertion, requester 0 SHALL have the highest priority.

Structure
REQ-042 A shared package m10k_pkg SHALL hold the state encodings and the default values of DATA_LEN, N and ADDRESS_SIZE, shared with the existing M10K write path.
REQ-043 The round-robin priority picker SHALL be a separate combinational sub-module rr_pick, with inputs req vector and pointer and outputs index and any-valid.
REQ-044 All other logic (FSM, counters, output mux) SHALL reside in m10k_wr_arb.

Verification
REQ-045 The bench SHALL cover a single requester: i_req=0001, base=4'd12, valid always high -> writes to addresses 12,13,14,15 on 4 consecutive cycles, then o_done=0001 for one cycle.
REQ-046 The bench SHALL cover contention: i_req=1111 held continuously after reset -> grants in order 0,1,2,3,0, each burst 4 writes, with no overlap.
REQ-047 The bench SHALL cover wrap-around: base=4'd14, BURST_LEN=4 -> addresses 14,15,0,1.
REQ-048 The bench SHALL cover stalls: valid dropped on beats 1 and 2 for 3 cycles each -> exactly 4 writes, o_done 6 cycles later than the no-stall case, addresses contiguous.
REQ-049 The bench SHALL cover reset mid-burst: i_rstn low after the 2nd write -> outputs zero in the same cycle, no o_done; after release with i_req=0010, requester 1 is granted and its burst starts at its own base.
REQ-050 The bench SHALL cover isolation: requester 2 toggles i_wr_valid and changes its data while requester 0 owns the port -> o_write_data always equals requester 0's slice, and o_beat_ack[2] stays 0.
